serial_cmd_engine: RTL and testbench
====================================

Name: serial_cmd_engine

Overview:
- Parametrised successor to the board's UART command processor; sits between the UART rx/tx byte interface and the trigger/PLL/histogram logic.
- Decodes single-byte commands plus argument bytes and drives the configuration registers and PLL reconfiguration pulse.
- Streams a histogram of configurable depth and bin width directly from a 1-cycle-latency read port, with no bulk copy.
- Adds an argument timeout, invalid-command error counting and a status readback command.

Parameters:
- NUM_BINS, 32: histogram bins streamed by SEND_HISTOGRAM.
- BIN_BYTES, 4: bytes per bin (1..4), sent little-endian.
- NUM_PLL, 6: PLL phase-shift bytes taken by SET_PLL.
- VERSION, 8'd24: firmware version byte.
- RX_TIMEOUT, 1000000: idle clk cycles allowed between argument bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rxReady  in  1  one-cycle strobe: rxData is valid.
- rxData  in  8  received byte.
- txBusy  in  1  UART transmitter busy.
- txStart  out  1  one-cycle transmit strobe.
- txData  out  8  byte to transmit.
- hist_addr  out  $clog2(NUM_BINS)  histogram bin address.
- hist_rdata  in  8*BIN_BYTES  bin value, valid one cycle after hist_addr.
- resethist  out  1  one-cycle histogram clear pulse.
- disable_line_drivers, enable_debug_outputs, passthrough, useInternalTestPulse, useExternalTestPulse  out  1 each  config bits.
- vetopmtlast  out  3  PMT veto setting.
- updatepll  out  1  one-cycle PLL reconfiguration pulse.
- pll_clk_src  out  1  PLL clock source select.
- pll_shifts  out  8*NUM_PLL  phase shifts; byte k sits at [8k+7:8k].
- err_count  out  8  saturating error counter.
- ledIndicators  out  8  debug LEDs.

Behaviour:
- Reset values: all 1-bit outputs 0, vetopmtlast=3'b001, pll_shifts=0, err_count=0, ledIndicators=0, hist_addr=0, txData=0.
- Reset mid-operation forces IDLE and aborts any argument collection or transmission in progress.
- States: IDLE, ARGS, EXEC, HFETCH, SEND, SENDWAIT, PLLUPD, ERR.
- Commands (argument count):
  - 0 VERSION (0): send VERSION.
  - 1 SET_OUTPUTS (1): disable_line_drivers=!a0[0], enable_debug_outputs=a0[1].
  - 2 SET_PLL (NUM_PLL): pll_shifts byte k = ak.
  - 3 SET_PASSTHROUGH (1): passthrough=(a0!=0).
  - 4 SEND_HISTOGRAM (0): stream the histogram.
  - 5 SET_PMT_VETO (1): vetopmtlast=a0[2:0].
  - 6 RESET_PLL (0): pll_shifts=0, pll_clk_src=0.
  - 7 SET_TEST_INPUTS (1): useInternalTestPulse=a0[0], useExternalTestPulse=a0[1].
  - 8 READ_STATUS (0): send err_count, then the last invalid command byte (0 if none).
- IDLE + rxReady:
  - Valid code (0..8): latch the code and set ledIndicators=rxData. Go to ARGS if the argument count is >0, else EXEC.
  - Invalid code (>=9): go to ERR.
- ARGS:
  - Each rxReady stores rxData at index cnt, then cnt++.
  - After the last argument, go to EXEC on the next cycle.
  - An idle counter resets on every rxReady. Reaching RX_TIMEOUT discards the partial command and goes to ERR.
- EXEC: applies the register writes in one cycle, then:
  - SET_PLL and RESET_PLL go to PLLUPD.
  - VERSION and READ_STATUS load the tx buffer and go to SEND.
  - SEND_HISTOGRAM goes to HFETCH.
  - All other commands go to IDLE.
- PLLUPD: updatepll=1 for exactly one cycle, then IDLE. pll_shifts is already stable when updatepll rises.
- ERR: err_count saturates at 255 (increments, never wraps), records the offending byte, sets ledIndicators=8'hFF, returns to IDLE in one cycle. Nothing is transmitted.
- HFETCH: drive hist_addr=bin, wait one cycle, capture hist_rdata into a shift register, go to SEND.
- SEND:
  - When txBusy=0: txData=next byte (LS byte first), txStart=1 for one cycle, go to SENDWAIT.
  - When txBusy=1: hold.
- SENDWAIT:
  - Lasts one cycle, during which txBusy is ignored; txStart=0.
  - If the current bin has bytes left, go to SEND.
  - Else if bins remain, bin++ and go to HFETCH.
  - Else go to IDLE.
- Histogram stream: exactly NUM_BINS*BIN_BYTES bytes, bin 0 first.
- resethist: one-cycle pulse in the cycle the final histogram byte's txStart is issued; clearing starts only after every bin has been read.
- rxReady outside IDLE and ARGS is dropped; it causes no error and no state change.
- ledIndicators[6]=1 while in SEND/SENDWAIT/HFETCH; [7] toggles per accepted argument byte.

Test Plan:
- Reset, then send 0x00 -> exactly one txStart with txData=0x18; state returns to IDLE; err_count=0.
- Send 0x02 then 01 02 03 04 05 06 -> pll_shifts=48'h060504030201; updatepll pulses exactly one cycle, after pll_shifts settles; 0x06 then zeroes pll_shifts with one more updatepll pulse.
- hist_rdata=bin index*0x01010101, send 0x04, txBusy held high 3 cycles after each txStart -> 128 bytes sent in order 00 00 00 00 01 01 01 01 ...; never txStart while txBusy=1; resethist pulses once, with the 128th txStart.
- Send 0x01 then wait RX_TIMEOUT cycles -> outputs unchanged; err_count=1; follow with 0x08 -> txData bytes 0x01, 0x01.
- Send 0x3F 300 times -> no txStart; err_count saturates at 0xFF; ledIndicators=0xFF.
- Assert reset mid-histogram after 10 bytes -> txStart low next cycle; all config outputs at their reset values; a following 0x00 gets a correct single-byte reply.

Source files
------------

// File: rtl/serial_cmd_engine_if.sv
// rtl/serial_cmd_engine_if.sv - UART byte-level handshake between engine and transceiver
interface serial_cmd_engine_if;
    logic       rxReady;
    logic [7:0] rxData;
    logic       txBusy;
    logic       txStart;
    logic [7:0] txData;

    modport master (input rxReady, input rxData, input txBusy, output txStart, output txData);
    modport slave  (output rxReady, output rxData, output txBusy, input txStart, input txData);
endinterface

// File: rtl/serial_cmd_engine.sv
// rtl/serial_cmd_engine.sv - UART command decoder driving config registers, PLL update and histogram streaming
module serial_cmd_engine #(
    parameter int         NUM_BINS   = 32,
    parameter int         BIN_BYTES  = 4,
    parameter int         NUM_PLL    = 6,
    parameter logic [7:0] VERSION    = 8'd24,
    parameter int         RX_TIMEOUT = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_cmd_engine_if.master           uart,
    output logic [$clog2(NUM_BINS)-1:0]   hist_addr,
    input  logic [8*BIN_BYTES-1:0]        hist_rdata,
    output logic                          resethist,
    output logic                          disable_line_drivers,
    output logic                          enable_debug_outputs,
    output logic                          passthrough,
    output logic                          useInternalTestPulse,
    output logic                          useExternalTestPulse,
    output logic [2:0]                    vetopmtlast,
    output logic                          updatepll,
    output logic                          pll_clk_src,
    output logic [8*NUM_PLL-1:0]          pll_shifts,
    output logic [7:0]                    err_count,
    output logic [7:0]                    ledIndicators
);
    localparam int AW        = $clog2(NUM_BINS);
    localparam int BUF_BYTES = (BIN_BYTES > 2) ? BIN_BYTES : 2;
    localparam int BUF_W     = 8 * BUF_BYTES;
    localparam int LW        = $clog2(BUF_BYTES + 1);
    localparam int CW        = $clog2(NUM_PLL + 1);
    localparam int TW        = $clog2(RX_TIMEOUT + 1);

    localparam logic [7:0] C_VERSION = 8'd0, C_OUTPUTS = 8'd1, C_PLL = 8'd2, C_PASS = 8'd3,
                           C_HIST = 8'd4, C_VETO = 8'd5, C_RSTPLL = 8'd6, C_TEST = 8'd7,
                           C_STATUS = 8'd8;

    typedef enum logic [2:0] {S_IDLE, S_ARGS, S_EXEC, S_HFETCH, S_SEND, S_SENDWAIT, S_PLLUPD, S_ERR} state_t;

    state_t             r_state, w_next;
    logic [7:0]         r_cmd, r_last_bad, r_err_count, r_led;
    logic [7:0]         r_args [NUM_PLL];
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_idle;
    logic [AW-1:0]      r_bin;
    logic               r_hist, r_phase;
    logic [BUF_W-1:0]   r_buf;
    logic [LW-1:0]      r_left;
    logic               r_dis, r_dbg, r_pass, r_int, r_ext, r_pll_src;
    logic [2:0]         r_veto;
    logic [8*NUM_PLL-1:0] r_pll;
    logic               w_last_arg, w_timeout, w_last_bin;

    function automatic logic [CW-1:0] arg_count(input logic [7:0] code);
        case (code)
            C_OUTPUTS, C_PASS, C_VETO, C_TEST: return CW'(1);
            C_PLL:                             return CW'(NUM_PLL);
            default:                           return '0;
        endcase
    endfunction

    assign w_last_arg = (r_cnt == arg_count(r_cmd) - CW'(1));
    assign w_timeout  = (r_idle == TW'(RX_TIMEOUT - 1));
    assign w_last_bin = (r_bin == AW'(NUM_BINS - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        uart.txStart = 1'b0;
        resethist    = 1'b0;
        updatepll    = 1'b0;
        case (r_state)
            S_IDLE: if (uart.rxReady) begin
                if (uart.rxData < 8'd9) w_next = (arg_count(uart.rxData) != '0) ? S_ARGS : S_EXEC;
                else                    w_next = S_ERR;
            end
            S_ARGS: begin
                if (uart.rxReady) begin
                    if (w_last_arg) w_next = S_EXEC;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_EXEC: case (r_cmd)
                C_PLL, C_RSTPLL:     w_next = S_PLLUPD;
                C_VERSION, C_STATUS: w_next = S_SEND;
                C_HIST:              w_next = S_HFETCH;
                default:             w_next = S_IDLE;
            endcase
            S_HFETCH: if (r_phase) w_next = S_SEND;
            S_SEND: if (!uart.txBusy) begin
                uart.txStart = 1'b1;
                // Clear is safe here: the last bin was already captured into r_buf.
                resethist    = r_hist && w_last_bin && (r_left == LW'(1));
                w_next       = S_SENDWAIT;
            end
            S_SENDWAIT: begin
                if (r_left != '0)               w_next = S_SEND;
                else if (r_hist && !w_last_bin) w_next = S_HFETCH;
                else                            w_next = S_IDLE;
            end
            S_PLLUPD: begin
                updatepll = 1'b1;
                w_next    = S_IDLE;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd <= '0; r_last_bad <= '0; r_err_count <= '0; r_led <= '0;
            for (int k = 0; k < NUM_PLL; k++) r_args[k] <= '0;
            r_cnt <= '0; r_idle <= '0; r_bin <= '0; r_hist <= 1'b0; r_phase <= 1'b0;
            r_buf <= '0; r_left <= '0;
            r_dis <= 1'b0; r_dbg <= 1'b0; r_pass <= 1'b0; r_int <= 1'b0; r_ext <= 1'b0;
            r_pll_src <= 1'b0; r_veto <= 3'b001; r_pll <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (uart.rxReady) begin
                    if (uart.rxData < 8'd9) begin
                        r_cmd  <= uart.rxData;
                        r_led  <= uart.rxData;
                        r_cnt  <= '0;
                        r_idle <= '0;
                    end else begin
                        r_last_bad <= uart.rxData;
                    end
                end
                S_ARGS: begin
                    if (uart.rxReady) begin
                        r_args[r_cnt] <= uart.rxData;
                        r_cnt         <= r_cnt + CW'(1);
                        r_idle        <= '0;
                        r_led[7]      <= ~r_led[7];
                    end else begin
                        r_idle <= r_idle + TW'(1);
                        // A stalled command is reported as the command byte itself.
                        if (w_timeout) r_last_bad <= r_cmd;
                    end
                end
                S_EXEC: case (r_cmd)
                    C_VERSION: begin r_buf <= BUF_W'(VERSION); r_left <= LW'(1); r_hist <= 1'b0; end
                    C_STATUS:  begin r_buf <= BUF_W'({r_last_bad, r_err_count}); r_left <= LW'(2); r_hist <= 1'b0; end
                    C_OUTPUTS: begin r_dis <= ~r_args[0][0]; r_dbg <= r_args[0][1]; end
                    C_PLL:     for (int k = 0; k < NUM_PLL; k++) r_pll[8*k +: 8] <= r_args[k];
                    C_PASS:    r_pass <= (r_args[0] != 8'd0);
                    C_HIST:    begin r_bin <= '0; r_hist <= 1'b1; r_phase <= 1'b0; end
                    C_VETO:    r_veto <= r_args[0][2:0];
                    C_RSTPLL:  begin r_pll <= '0; r_pll_src <= 1'b0; end
                    C_TEST:    begin r_int <= r_args[0][0]; r_ext <= r_args[0][1]; end
                    default:   ;
                endcase
                S_HFETCH: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_buf  <= BUF_W'(hist_rdata);
                        r_left <= LW'(BIN_BYTES);
                    end
                end
                S_SEND: if (!uart.txBusy) begin
                    r_buf  <= r_buf >> 8;
                    r_left <= r_left - LW'(1);
                end
                S_SENDWAIT: if (r_left == '0 && r_hist && !w_last_bin) r_bin <= r_bin + AW'(1);
                S_ERR: begin
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    r_led <= 8'hFF;
                end
                default: ;
            endcase
        end
    end

    assign uart.txData          = r_buf[7:0];
    assign hist_addr            = r_bin;
    assign disable_line_drivers = r_dis;
    assign enable_debug_outputs = r_dbg;
    assign passthrough          = r_pass;
    assign useInternalTestPulse = r_int;
    assign useExternalTestPulse = r_ext;
    assign vetopmtlast          = r_veto;
    assign pll_clk_src          = r_pll_src;
    assign pll_shifts           = r_pll;
    assign err_count            = r_err_count;
    assign ledIndicators        = r_led | (((r_state == S_SEND) || (r_state == S_SENDWAIT) ||
                                            (r_state == S_HFETCH)) ? 8'h40 : 8'h00);
endmodule

// File: tb/tb_serial_cmd_engine.sv
// tb/tb_serial_cmd_engine.sv - directed self-checking bench for serial_cmd_engine
module tb_serial_cmd_engine;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  hist_addr;
    logic [31:0] hist_rdata = '0;
    logic        resethist, disable_line_drivers, enable_debug_outputs, passthrough;
    logic        useInternalTestPulse, useExternalTestPulse, updatepll, pll_clk_src;
    logic [2:0]  vetopmtlast;
    logic [47:0] pll_shifts;
    logic [7:0]  err_count, ledIndicators;

    serial_cmd_engine_if u_if();

    serial_cmd_engine #(.RX_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .uart(u_if.master),
        .hist_addr(hist_addr), .hist_rdata(hist_rdata), .resethist(resethist),
        .disable_line_drivers(disable_line_drivers), .enable_debug_outputs(enable_debug_outputs),
        .passthrough(passthrough), .useInternalTestPulse(useInternalTestPulse),
        .useExternalTestPulse(useExternalTestPulse), .vetopmtlast(vetopmtlast),
        .updatepll(updatepll), .pll_clk_src(pll_clk_src), .pll_shifts(pll_shifts),
        .err_count(err_count), .ledIndicators(ledIndicators)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_q[$];
    int         busy_cnt = 0;
    int         busy_viol = 0;
    int         upd_cycles = 0;
    logic [47:0] pll_at_upd = '0;
    int         rh_count = 0;
    int         rh_at = -1;

    // Histogram memory with one cycle read latency: bin b holds b*0x01010101.
    always @(posedge clk) hist_rdata <= {4{3'b000, hist_addr}};

    // Byte monitor plus UART transmitter model (busy for 3 cycles after each start).
    always @(negedge clk) begin
        if (u_if.txStart && u_if.txBusy) busy_viol++;
        if (u_if.txStart) tx_q.push_back(u_if.txData);
        if (resethist) begin rh_count++; rh_at = tx_q.size(); end
        if (updatepll) begin upd_cycles++; pll_at_upd = pll_shifts; end
        if (u_if.txStart)      busy_cnt = 3;
        else if (busy_cnt > 0) busy_cnt--;
        u_if.txBusy = (busy_cnt != 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_if.rxReady = 1'b1;
        u_if.rxData  = b;
        @(negedge clk);
        u_if.rxReady = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [4:0] cfg_bits();
        return {disable_line_drivers, enable_debug_outputs, passthrough,
                useInternalTestPulse, useExternalTestPulse};
    endfunction

    task automatic check_reset_vals(input string sfx);
        chk({"rst_txStart", sfx}, u_if.txStart, 1'b0);
        chk({"rst_txData", sfx}, u_if.txData, 8'h00);
        chk({"rst_cfg", sfx}, cfg_bits(), 5'b0);
        chk({"rst_pulses", sfx}, {resethist, updatepll, pll_clk_src}, 3'b0);
        chk({"rst_veto", sfx}, vetopmtlast, 3'b001);
        chk({"rst_pll", sfx}, pll_shifts, 48'h0);
        chk({"rst_err", sfx}, err_count, 8'h00);
        chk({"rst_led", sfx}, ledIndicators, 8'h00);
        chk({"rst_addr", sfx}, hist_addr, 5'd0);
    endtask

    initial begin
        logic [4:0]  cfg_saved;
        logic [2:0]  veto_saved;
        int          bad;
        u_if.rxReady = 1'b0;
        u_if.rxData  = 8'h00;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_reset_vals("");

        // VERSION
        send_byte(8'h00);
        idle(10);
        chk("ver_count", tx_q.size(), 1);
        chk("ver_byte", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'h18);
        chk("ver_err", err_count, 8'h00);
        chk("ver_led", ledIndicators, 8'h00);

        // SET_PLL then RESET_PLL
        send_byte(8'h02);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        idle(5);
        chk("pll_val", pll_shifts, 48'h060504030201);
        chk("pll_upd_cycles", upd_cycles, 1);
        chk("pll_at_upd", pll_at_upd, 48'h060504030201);
        chk("pll_led", ledIndicators, 8'h02);
        send_byte(8'h06);
        idle(5);
        chk("rstpll_val", pll_shifts, 48'h0);
        chk("rstpll_upd_cycles", upd_cycles, 2);
        chk("rstpll_at_upd", pll_at_upd, 48'h0);

        // Single-argument config commands
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h05);
        send_byte(8'h05); send_byte(8'h06);
        send_byte(8'h07); send_byte(8'h03);
        idle(4);
        chk("cfg_bits", cfg_bits(), 5'b11111);
        chk("cfg_veto", vetopmtlast, 3'd6);
        send_byte(8'h01); send_byte(8'h01);
        idle(4);
        chk("cfg_outputs2", {disable_line_drivers, enable_debug_outputs}, 2'b00);
        chk("cfg_led_toggle", ledIndicators, 8'h81);

        // Full histogram stream
        tx_q.delete();
        send_byte(8'h04);
        idle(20);
        chk("hist_led_busy", ledIndicators, 8'h44);
        for (int i = 0; i < 3000 && tx_q.size() < 128; i++) @(negedge clk);
        idle(20);
        chk("hist_count", tx_q.size(), 128);
        bad = 0;
        for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== 8'(i / 4)) bad++;
        chk("hist_bytes_bad", bad, 0);
        chk("hist_busy_viol", busy_viol, 0);
        chk("hist_resethist_count", rh_count, 1);
        chk("hist_resethist_at", rh_at, 128);
        chk("hist_led_after", ledIndicators, 8'h04);

        // Argument timeout
        cfg_saved  = cfg_bits();
        veto_saved = vetopmtlast;
        send_byte(8'h01);
        idle(TMO + 10);
        chk("tmo_cfg", cfg_bits(), cfg_saved);
        chk("tmo_veto", vetopmtlast, veto_saved);
        chk("tmo_err", err_count, 8'h01);
        chk("tmo_led", ledIndicators, 8'hFF);
        tx_q.delete();
        send_byte(8'h08);
        idle(20);
        chk("status1_count", tx_q.size(), 2);
        chk("status1_b0", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'h01);
        chk("status1_b1", tx_q.size() > 1 ? tx_q[1] : 8'hXX, 8'h01);

        // Invalid command flood and saturation
        tx_q.delete();
        for (int i = 0; i < 100; i++) send_byte(8'h3F);
        idle(2);
        chk("sat_err_101", err_count, 8'd101);
        for (int i = 0; i < 200; i++) send_byte(8'h3F);
        idle(2);
        chk("sat_err_ff", err_count, 8'hFF);
        chk("sat_no_tx", tx_q.size(), 0);
        chk("sat_led", ledIndicators, 8'hFF);
        send_byte(8'h08);
        idle(20);
        chk("status2_count", tx_q.size(), 2);
        chk("status2_b0", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'hFF);
        chk("status2_b1", tx_q.size() > 1 ? tx_q[1] : 8'hXX, 8'h3F);

        // Reset in the middle of a histogram stream
        tx_q.delete();
        send_byte(8'h04);
        for (int i = 0; i < 1000 && tx_q.size() < 10; i++) @(negedge clk);
        chk("midrst_reached10", tx_q.size(), 10);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_txStart", u_if.txStart, 1'b0);
        reset = 1'b0;
        check_reset_vals("_mid");
        idle(20);
        chk("midrst_no_more_tx", tx_q.size(), 10);
        tx_q.delete();
        send_byte(8'h00);
        idle(10);
        chk("midrst_ver_count", tx_q.size(), 1);
        chk("midrst_ver_byte", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'h18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
